// File: rtl/pulse_train_monitor_pkg.sv
// Shared types and defaults for the pulse train monitor: FSM state encoding,
// default burst shape and the control bundle for the saturating counters.
package pulse_train_monitor_pkg;

    localparam int N_MAX = 4;
    localparam int M_MAX = 3;

    typedef enum logic [1:0] {
        PTM_IDLE = 2'd0,
        PTM_HIGH = 2'd1,
        PTM_GAP  = 2'd2,
        PTM_DONE = 2'd3
    } ptm_state_t;

    // Counter slots inside the monitor's counter array.
    localparam int CTR_HI   = 0;
    localparam int CTR_GAP  = 1;
    localparam int NUM_CTRS = 2;

    typedef struct packed {
        logic clear;
        logic load_one;
        logic inc;
    } ctr_ctrl_t;

endpackage

// File: rtl/pulse_train_monitor_if.sv
// Monitor-side bundle: arming/sample inputs plus the measurement and status outputs.
interface pulse_train_monitor_if #(
    parameter int CNT_W = 4
);
    logic             enable;
    logic             din;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] burst_cnt;
    logic             burst_valid;
    logic             len_err;
    logic             gap_err;
    logic             extra_err;
    logic             done;

    modport master (
        output enable, din,
        input  run_len, burst_cnt, burst_valid, len_err, gap_err, extra_err, done
    );

    modport slave (
        input  enable, din,
        output run_len, burst_cnt, burst_valid, len_err, gap_err, extra_err, done
    );
endinterface

// File: rtl/pulse_train_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one; clear wins over load,
// load wins over increment, and the count sticks at all-ones.
module sat_counter
    import pulse_train_monitor_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  ctr_ctrl_t        ctrl,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (ctrl.clear) begin
            count_next = '0;
        end else if (ctrl.load_one) begin
            count_next = CNT_ONE;
        end else if (ctrl.inc && (count_reg != CNT_MAX)) begin
            count_next = count_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pulse_train_monitor.sv
// Receive-side pulse train checker: measures each high run and low gap on din,
// counts bursts, raises sticky length/gap/extra-pulse errors and holds done.
module pulse_train_monitor
    import pulse_train_monitor_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int EXP_HIGH   = N_MAX,
    parameter int EXP_BURSTS = M_MAX,
    parameter int GAP_MAX    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    pulse_train_monitor_if.slave  mon
);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] EXP_HIGH_C   = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0] EXP_BURSTS_C = CNT_W'(EXP_BURSTS);
    // gap_cnt already holds the lows seen so far; the next low is the one that times out.
    localparam logic [CNT_W-1:0] GAP_LAST_C   = CNT_W'(GAP_MAX - 1);

    ptm_state_t       state_reg, state_next;
    logic [CNT_W-1:0] run_len_reg, run_len_next;
    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
    logic             burst_valid_reg, burst_valid_next;
    logic             len_err_reg, len_err_next;
    logic             gap_err_reg, gap_err_next;
    logic             extra_err_reg, extra_err_next;
    logic             done_reg, done_next;
    logic [CNT_W-1:0] burst_inc;

    ctr_ctrl_t        ctr_ctrl  [NUM_CTRS];
    logic [CNT_W-1:0] ctr_count [NUM_CTRS];
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] gap_cnt;

    for (genvar gi = 0; gi < NUM_CTRS; gi++) begin : g_ctr
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_ctr (
            .clk   (clk),
            .reset (reset),
            .ctrl  (ctr_ctrl[gi]),
            .count (ctr_count[gi])
        );
    end

    assign hi_cnt  = ctr_count[CTR_HI];
    assign gap_cnt = ctr_count[CTR_GAP];

    always_comb begin
        state_next       = state_reg;
        run_len_next     = run_len_reg;
        burst_cnt_next   = burst_cnt_reg;
        burst_valid_next = 1'b0;
        len_err_next     = len_err_reg;
        gap_err_next     = gap_err_reg;
        extra_err_next   = extra_err_reg;
        done_next        = done_reg;
        ctr_ctrl[CTR_HI]  = '0;
        ctr_ctrl[CTR_GAP] = '0;
        burst_inc        = burst_cnt_reg + CNT_ONE;

        if (!mon.enable) begin
            // Disarm: drop any partial run silently; sticky errors survive.
            state_next                 = PTM_IDLE;
            run_len_next               = '0;
            burst_cnt_next             = '0;
            done_next                  = 1'b0;
            ctr_ctrl[CTR_HI].clear     = 1'b1;
            ctr_ctrl[CTR_GAP].clear    = 1'b1;
        end else begin
            unique case (state_reg)
                PTM_IDLE: begin
                    if (mon.din) begin
                        state_next                = PTM_HIGH;
                        ctr_ctrl[CTR_HI].load_one = 1'b1;
                    end
                end
                PTM_HIGH: begin
                    if (mon.din) begin
                        ctr_ctrl[CTR_HI].inc = 1'b1;
                    end else begin
                        run_len_next     = hi_cnt;
                        burst_cnt_next   = burst_inc;
                        burst_valid_next = 1'b1;
                        if (hi_cnt != EXP_HIGH_C) begin
                            len_err_next = 1'b1;
                        end
                        if (burst_inc == EXP_BURSTS_C) begin
                            state_next = PTM_DONE;
                            done_next  = 1'b1;
                        end else begin
                            state_next                 = PTM_GAP;
                            ctr_ctrl[CTR_GAP].load_one = 1'b1;
                        end
                    end
                end
                PTM_GAP: begin
                    if (mon.din) begin
                        state_next                = PTM_HIGH;
                        ctr_ctrl[CTR_HI].load_one = 1'b1;
                    end else begin
                        ctr_ctrl[CTR_GAP].inc = 1'b1;
                        if (gap_cnt >= GAP_LAST_C) begin
                            gap_err_next = 1'b1;
                            done_next    = 1'b1;
                            state_next   = PTM_DONE;
                        end
                    end
                end
                PTM_DONE: begin
                    done_next = 1'b1;
                    if (mon.din) begin
                        extra_err_next = 1'b1;
                    end
                end
                default: begin
                    state_next = PTM_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= PTM_IDLE;
            run_len_reg     <= '0;
            burst_cnt_reg   <= '0;
            burst_valid_reg <= 1'b0;
            len_err_reg     <= 1'b0;
            gap_err_reg     <= 1'b0;
            extra_err_reg   <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            run_len_reg     <= run_len_next;
            burst_cnt_reg   <= burst_cnt_next;
            burst_valid_reg <= burst_valid_next;
            len_err_reg     <= len_err_next;
            gap_err_reg     <= gap_err_next;
            extra_err_reg   <= extra_err_next;
            done_reg        <= done_next;
        end
    end

    assign mon.run_len     = run_len_reg;
    assign mon.burst_cnt   = burst_cnt_reg;
    assign mon.burst_valid = burst_valid_reg;
    assign mon.len_err     = len_err_reg;
    assign mon.gap_err     = gap_err_reg;
    assign mon.extra_err   = extra_err_reg;
    assign mon.done        = done_reg;

endmodule

// File: tb/tb_pulse_train_monitor.sv
// Bench for pulse_train_monitor: directed burst scenarios plus random pulse trains,
// checked each cycle against a run/gap-length model of the monitor's rules.
module tb_pulse_train_monitor;

    localparam int CNT_W      = 4;
    localparam int EXP_HIGH   = 4;
    localparam int EXP_BURSTS = 3;
    localparam int GAP_MAX    = 4;
    localparam int RUN_CAP    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pulse_train_monitor_if #(.CNT_W(CNT_W)) bus();

    pulse_train_monitor #(
        .CNT_W      (CNT_W),
        .EXP_HIGH   (EXP_HIGH),
        .EXP_BURSTS (EXP_BURSTS),
        .GAP_MAX    (GAP_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;

    // Model: length of the current high run, lows since the last run ended,
    // bursts since arming, and whether the train is finished.
    int m_run = 0, m_low = 0, m_bursts = 0;
    bit m_fin = 0, model_ok = 0;
    int e_run_len = 0, e_burst_cnt = 0;
    bit e_bv = 0, e_len = 0, e_gap = 0, e_extra = 0, e_done = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit en, input bit d);
        if (r) begin
            m_run = 0; m_low = 0; m_bursts = 0; m_fin = 0;
            e_run_len = 0; e_burst_cnt = 0; e_bv = 0;
            e_len = 0; e_gap = 0; e_extra = 0; e_done = 0;
            model_ok = 1;
        end else if (!en) begin
            m_run = 0; m_low = 0; m_bursts = 0; m_fin = 0;
            e_run_len = 0; e_burst_cnt = 0; e_bv = 0; e_done = 0;
        end else begin
            e_bv = 0;
            if (m_fin) begin
                if (d) e_extra = 1;
            end else if (d) begin
                m_run++;
                m_low = 0;
            end else if (m_run > 0) begin
                e_run_len = (m_run > RUN_CAP) ? RUN_CAP : m_run;
                if (m_run != EXP_HIGH) e_len = 1;
                m_bursts++;
                e_burst_cnt = m_bursts;
                e_bv = 1;
                m_run = 0;
                if (m_bursts == EXP_BURSTS) begin
                    m_fin = 1;
                    e_done = 1;
                end else begin
                    m_low = 1;
                end
            end else if (m_low > 0) begin
                m_low++;
                if (m_low >= GAP_MAX) begin
                    e_gap = 1;
                    e_done = 1;
                    m_fin = 1;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit en, input bit d);
        reset = r;
        bus.enable = en;
        bus.din = d;
        @(posedge clk);
        model_update(r, en, d);
        #2;
    endtask

    task automatic run(input bit en, input bit d, input int n);
        for (int i = 0; i < n; i++) step(1'b0, en, d);
    endtask

    task automatic burst(input int h, input int g);
        run(1'b1, 1'b1, h);
        run(1'b1, 1'b0, g);
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("run_len",     int'(bus.run_len),     e_run_len);
            chk("burst_cnt",   int'(bus.burst_cnt),   e_burst_cnt);
            chk("burst_valid", int'(bus.burst_valid), int'(e_bv));
            chk("len_err",     int'(bus.len_err),     int'(e_len));
            chk("gap_err",     int'(bus.gap_err),     int'(e_gap));
            chk("extra_err",   int'(bus.extra_err),   int'(e_extra));
            chk("done",        int'(bus.done),        int'(e_done));
            if (bus.burst_valid === 1'b1) strobes++;
        end
    end

    initial begin
        bus.enable = 1'b0;
        bus.din = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        chk("rst_run_len", int'(bus.run_len), 0);
        chk("rst_burst_cnt", int'(bus.burst_cnt), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_errs", int'({bus.len_err, bus.gap_err, bus.extra_err}), 0);

        // Nominal: 3 bursts of 4 highs, 2-low gaps
        strobes = 0;
        step(1'b0, 1'b1, 0);
        burst(4, 2);
        burst(4, 2);
        run(1'b1, 1'b1, 4);
        step(1'b0, 1'b1, 0);
        chk("nom_valid", int'(bus.burst_valid), 1);
        chk("nom_done", int'(bus.done), 1);
        chk("nom_run_len", int'(bus.run_len), 4);
        chk("nom_burst_cnt", int'(bus.burst_cnt), 3);
        step(1'b0, 1'b1, 0);
        chk("nom_strobes", strobes, 3);
        chk("nom_errs", int'({bus.len_err, bus.gap_err, bus.extra_err}), 0);

        // Extra pulse after done
        step(1'b0, 1'b1, 1);
        chk("extra_err", int'(bus.extra_err), 1);
        chk("extra_done", int'(bus.done), 1);
        step(1'b0, 1'b1, 0);

        // Abort mid-run, then re-arm and run nominal
        step(1'b0, 1'b0, 0);
        strobes = 0;
        step(1'b0, 1'b1, 1);
        step(1'b0, 1'b1, 1);
        step(1'b0, 1'b0, 0);
        chk("abort_burst_cnt", int'(bus.burst_cnt), 0);
        chk("abort_done", int'(bus.done), 0);
        step(1'b0, 1'b0, 0);
        chk("abort_strobes", strobes, 0);
        step(1'b0, 1'b1, 0);
        burst(4, 2);
        burst(4, 2);
        run(1'b1, 1'b1, 4);
        step(1'b0, 1'b1, 0);
        chk("rearm_done", int'(bus.done), 1);
        chk("rearm_burst_cnt", int'(bus.burst_cnt), 3);

        // Short second run
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        burst(4, 2);
        run(1'b1, 1'b1, 3);
        step(1'b0, 1'b1, 0);
        chk("short_run_len", int'(bus.run_len), 3);
        chk("short_len_err", int'(bus.len_err), 1);
        step(1'b0, 1'b1, 0);
        run(1'b1, 1'b1, 4);
        step(1'b0, 1'b1, 0);
        chk("short_done", int'(bus.done), 1);
        chk("short_len_err_held", int'(bus.len_err), 1);

        // Gap timeout after burst 1
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        run(1'b1, 1'b1, 4);
        run(1'b1, 1'b0, 3);
        chk("gap_not_yet", int'(bus.done), 0);
        step(1'b0, 1'b1, 0);
        chk("gap_err", int'(bus.gap_err), 1);
        chk("gap_done", int'(bus.done), 1);
        chk("gap_burst_cnt", int'(bus.burst_cnt), 1);

        // Reset mid-gap with errors set
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        run(1'b1, 1'b1, 3);
        run(1'b1, 1'b0, 2);
        step(1'b1, 1'b1, 0);
        chk("rstgap_outs", int'({bus.len_err, bus.gap_err, bus.extra_err, bus.done, bus.burst_valid}), 0);
        chk("rstgap_burst_cnt", int'(bus.burst_cnt), 0);

        // Saturation of the run counter
        step(1'b0, 1'b1, 0);
        run(1'b1, 1'b1, 20);
        step(1'b0, 1'b1, 0);
        chk("sat_run_len", int'(bus.run_len), 15);
        chk("sat_len_err", int'(bus.len_err), 1);

        // Random pulse trains
        step(1'b1, 1'b0, 0);
        for (int k = 0; k < 300; k++) begin
            int r, h, g;
            r = int'($urandom_range(0, 39));
            h = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : EXP_HIGH;
            g = int'($urandom_range(1, 5));
            if (r == 0) begin
                step(1'b1, 1'b0, 0);
            end else if (r < 3) begin
                run(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(1, 2)));
            end else begin
                burst(h, g);
            end
        end
        step(1'b0, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
